// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg
//   Shared definitions for the Tomasulo core functional units.
//   - TAG_W_DEF      : default reservation-station tag width
//   - fu_op_e        : add/sub FU op encoding (OP_ADD=0, OP_SUB=1)
//   - CDB_*_W        : common-data-bus result field widths
//   - op_cin()       : carry-in into the LSB for a given op
package tomasulo_pkg;

   localparam int unsigned TAG_W_DEF  = 4;
   localparam int unsigned XLEN       = 32;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } fu_op_e;

   localparam int unsigned CDB_TAG_W  = TAG_W_DEF;
   localparam int unsigned CDB_DATA_W = XLEN;
   localparam int unsigned CDB_FLAG_W = 2;   // carry, overflow

   // Subtraction is A + ~B + 1, so the +1 enters as the LSB carry-in.
   function automatic logic op_cin(input fu_op_e op);
      return (op == OP_SUB);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice
//   Combinational C-bit ripple-carry adder slice.
//   Ports:
//     a, b  in  [C-1:0]  operand slices
//     cin   in  1        carry into bit 0
//     sum   out [C-1:0]  slice sum
//     cout  out 1        carry out of bit C-1
//     cmsb  out 1        carry into bit C-1 (cout ^ cmsb = signed overflow)
module adder_slice #(
   parameter int unsigned C = 16
) (
   input  logic [C-1:0] a,
   input  logic [C-1:0] b,
   input  logic         cin,
   output logic [C-1:0] sum,
   output logic         cout,
   output logic         cmsb
);

   logic [C:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int unsigned i = 0; i < C; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[C];
   assign cmsb = carry[C - 1];

endmodule

// File: rtl/pipelined_adder_unit.sv
// pipelined_adder_unit
//   Pipelined integer add/sub functional unit feeding the CDB. The carry
//   chain is split into STAGES equal slices, one per pipeline stage; upper
//   operand slices and the tag travel alongside, finished low sum slices
//   are carried forward. Latency = STAGES cycles, one op per cycle.
//   Optional feature macro: ADDER_SUB_EN (in_sub honoured; otherwise always add).
//   Ports:
//     clk, rst_n            clock (rising), async active-low reset
//     flush                 synchronous kill of all in-flight ops
//     in_valid/in_ready     issue handshake; in_tag, in_a, in_b, in_sub operands
//     out_valid/out_ready   CDB handshake
//     out_tag, out_sum      result tag and sum (mod 2^WIDTH)
//     out_carry, out_ovf    MSB carry-out (sub: 1 = no borrow), signed overflow
module pipelined_adder_unit
   import tomasulo_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = TAG_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_ovf
);

   localparam int unsigned C = WIDTH / ((STAGES == 0) ? 1 : STAGES);

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_adder_unit: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   fu_op_e           op;
   logic             cin0;
   logic [WIDTH-1:0] b_eff;
   logic             advance;

`ifdef ADDER_SUB_EN
   assign op = in_sub ? OP_SUB : OP_ADD;
`else
   logic unused_sub;
   assign unused_sub = in_sub;
   assign op         = OP_ADD;
`endif

   assign cin0     = op_cin(op);
   assign b_eff    = (op == OP_SUB) ? ~in_b : in_b;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int unsigned LO  = k * C;
      localparam int unsigned REM = WIDTH - LO;   // operand bits not yet summed

      logic [REM-1:0]    a_in, b_in;
      logic              c_in, v_in;
      logic [TAG_W-1:0]  t_in;
      logic [C-1:0]      s;
      logic              co, cm;
      logic [LO+C-1:0]   sum_nxt, sum_q;
      logic              v_q, c_q;
      logic [TAG_W-1:0]  t_q;

      if (k == 0) begin : g_src
         assign a_in    = in_a;
         assign b_in    = b_eff;
         assign c_in    = cin0;
         assign v_in    = in_valid;
         assign t_in    = in_tag;
         assign sum_nxt = s;
      end else begin : g_src
         assign a_in    = g_st[k-1].g_fwd.a_q;
         assign b_in    = g_st[k-1].g_fwd.b_q;
         assign c_in    = g_st[k-1].c_q;
         assign v_in    = g_st[k-1].v_q;
         assign t_in    = g_st[k-1].t_q;
         assign sum_nxt = {s, g_st[k-1].sum_q};
      end

      adder_slice #(.C(C)) u_slice (
         .a    (a_in[C-1:0]),
         .b    (b_in[C-1:0]),
         .cin  (c_in),
         .sum  (s),
         .cout (co),
         .cmsb (cm)
      );

      // Whole pipe moves together on advance; flush clears only valid bits.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            t_q   <= '0;
            sum_q <= '0;
         end else begin
            if (flush)        v_q <= 1'b0;
            else if (advance) v_q <= v_in;
            if (advance) begin
               c_q   <= co;
               t_q   <= t_in;
               sum_q <= sum_nxt;
            end
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [REM-C-1:0] a_q, b_q;
         logic             unused_cm;
         assign unused_cm = cm;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= a_in[REM-1:C];
               b_q <= b_in[REM-1:C];
            end
         end
      end else begin : g_out
         logic ovf_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       ovf_q <= 1'b0;
            else if (advance) ovf_q <= co ^ cm;
         end

         assign out_valid = v_q;
         assign out_tag   = t_q;
         assign out_sum   = sum_q;
         assign out_carry = c_q;
         assign out_ovf   = ovf_q;
      end
   end

endmodule

// File: tb/tb_pipelined_adder_unit.sv
module tb_pipelined_adder_unit;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 2;
   localparam int unsigned TAG_W  = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [TAG_W-1:0] in_tag;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [TAG_W-1:0] out_tag;
   logic [WIDTH-1:0] out_sum;
   logic             out_carry;
   logic             out_ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipelined_adder_unit #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_tag    (in_tag),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tag   (out_tag),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_ovf   (out_ovf)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_tag = '0;
      in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
      repeat (2) step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_sum !== 32'h0) begin failures++; $display("FAIL rst_out_sum: got %h expected 0", out_sum); end
      checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL rst_out_tag: got %h expected 0", out_tag); end
      checks++; if ({out_carry, out_ovf} !== 2'b00) begin failures++; $display("FAIL rst_flags: got %b expected 00", {out_carry, out_ovf}); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
      rst_n = 1'b1;
      step();
      // two ops in flight, then reset mid-stream
      in_valid = 1'b1; in_a = 32'd1; in_b = 32'd2; in_tag = 4'd1;
      step();
      in_tag = 4'd2;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_async_valid: got %b expected 0", out_valid); end
      checks++; if (out_sum !== 32'h0) begin failures++; $display("FAIL midrst_async_sum: got %h expected 0", out_sum); end
      step();
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_output[%0d]: got %b expected 0", i, out_valid); end
      end
   endtask

   task automatic test_add();
      logic [31:0] va [4] = '{32'h0000FFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h12345678};
      logic [31:0] vb [4] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h11111111};
      logic [3:0]  vt [4] = '{4'd3, 4'd5, 4'd6, 4'd7};
      logic [31:0] es [4] = '{32'h00010000, 32'h80000000, 32'h00000000, 32'h23456789};
      logic        ec [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_tag = vt[i]; in_sub = 1'b0;
         step();
         in_valid = 1'b0;
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_early[%0d]: got %b expected 0", i, out_valid); end
         step();
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid[%0d]: got %b expected 1", i, out_valid); end
         checks++; if (out_sum !== es[i]) begin failures++; $display("FAIL add_sum[%0d]: got %h expected %h", i, out_sum, es[i]); end
         checks++; if (out_carry !== ec[i]) begin failures++; $display("FAIL add_carry[%0d]: got %b expected %b", i, out_carry, ec[i]); end
         checks++; if (out_ovf !== eo[i]) begin failures++; $display("FAIL add_ovf[%0d]: got %b expected %b", i, out_ovf, eo[i]); end
         checks++; if (out_tag !== vt[i]) begin failures++; $display("FAIL add_tag[%0d]: got %h expected %h", i, out_tag, vt[i]); end
         step();
      end
   endtask

   task automatic test_sub();
      logic [31:0] va [3] = '{32'd5, 32'h80000000, 32'd7};
      logic [31:0] vb [3] = '{32'd7, 32'h00000001, 32'd5};
`ifdef ADDER_SUB_EN
      logic [31:0] es [3] = '{32'hFFFFFFFE, 32'h7FFFFFFF, 32'h00000002};
      logic        ec [3] = '{1'b0, 1'b1, 1'b1};
      logic        eo [3] = '{1'b0, 1'b1, 1'b0};
`else
      logic [31:0] es [3] = '{32'd12, 32'h80000001, 32'd12};
      logic        ec [3] = '{1'b0, 1'b0, 1'b0};
      logic        eo [3] = '{1'b0, 1'b0, 1'b0};
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_tag = 4'(8 + i); in_sub = 1'b1;
         step();
         in_valid = 1'b0; in_sub = 1'b0;
         step();
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sub_valid[%0d]: got %b expected 1", i, out_valid); end
         checks++; if (out_sum !== es[i]) begin failures++; $display("FAIL sub_sum[%0d]: got %h expected %h", i, out_sum, es[i]); end
         checks++; if (out_carry !== ec[i]) begin failures++; $display("FAIL sub_carry[%0d]: got %b expected %b", i, out_carry, ec[i]); end
         checks++; if (out_ovf !== eo[i]) begin failures++; $display("FAIL sub_ovf[%0d]: got %b expected %b", i, out_ovf, eo[i]); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      int          next_tag   = 1;
      int          exp_tag    = 1;
      int          got        = 0;
      int          stall_left = 0;
      bit          started    = 1'b0;
      logic [31:0] exp_sum;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (out_valid === 1'b1 && !started) begin
            started    = 1'b1;
            stall_left = 3;
         end
         out_ready = (stall_left == 0);
         in_valid  = (next_tag <= 4);
         in_tag    = 4'(next_tag);
         in_a      = 32'h0000FFFF + (32'(next_tag) << 24);
         in_b      = 32'h00000001;
         in_sub    = 1'b0;
         #1;
         exp_sum = 32'h00010000 + (32'(exp_tag) << 24);
         if (stall_left > 0) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", cyc, in_ready); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b expected 1", cyc, out_valid); end
            checks++; if (out_tag !== 4'(exp_tag)) begin failures++; $display("FAIL stall_tag[%0d]: got %h expected %h", cyc, out_tag, 4'(exp_tag)); end
            checks++; if (out_sum !== exp_sum) begin failures++; $display("FAIL stall_sum[%0d]: got %h expected %h", cyc, out_sum, exp_sum); end
            stall_left--;
         end else if (got > 0 && got < 4) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_bubble[%0d]: got %b expected 1", cyc, out_valid); end
         end
         if (in_valid && in_ready === 1'b1) next_tag++;
         if (out_valid === 1'b1 && out_ready) begin
            if (got >= 4) begin
               checks++; failures++; $display("FAIL b2b_extra[%0d]: got tag %h expected none", cyc, out_tag);
            end else begin
               checks++; if (out_tag !== 4'(exp_tag)) begin failures++; $display("FAIL b2b_tag[%0d]: got %h expected %h", cyc, out_tag, 4'(exp_tag)); end
               checks++; if (out_sum !== exp_sum) begin failures++; $display("FAIL b2b_sum[%0d]: got %h expected %h", cyc, out_sum, exp_sum); end
               exp_tag++;
               got++;
            end
         end
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got !== 4) begin failures++; $display("FAIL b2b_count: got %0d expected 4", got); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b1; in_sub = 1'b0;
      in_valid = 1'b1; in_a = 32'd10; in_b = 32'd20; in_tag = 4'd1;
      step();
      in_tag = 4'd2;
      step();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid: got %b expected 1", out_valid); end
      flush = 1'b1; in_tag = 4'd3;
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid0: got %b expected 0", out_valid); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid1: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
      in_valid = 1'b1; in_a = 32'h00FF00FF; in_b = 32'h0001FF01; in_tag = 4'd12;
      step();
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_after_valid: got %b expected 1", out_valid); end
      checks++; if (out_sum !== 32'h01010000) begin failures++; $display("FAIL flush_after_sum: got %h expected 01010000", out_sum); end
      checks++; if (out_tag !== 4'd12) begin failures++; $display("FAIL flush_after_tag: got %h expected c", out_tag); end
      step();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
